// File: rtl/led_pattern_sequencer.sv
// Drives four user LEDs in blink, running-light, breathing (PWM) or off mode.
// A debounced push-button steps through the modes; a prescaler paces the patterns.
module led_pattern_sequencer #(
    parameter int TICK_DIV    = 25000000,
    parameter int DEB_CYCLES  = 1000000,
    parameter int PWM_BITS    = 8,
    parameter int BREATHE_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_n,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic       step_tick
);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int DEB_W  = $clog2(DEB_CYCLES);
    localparam int BR_W   = $clog2(BREATHE_DIV);

    localparam logic [1:0] MODE_BLINK   = 2'd0;
    localparam logic [1:0] MODE_RUN     = 2'd1;
    localparam logic [1:0] MODE_BREATHE = 2'd2;
    localparam logic [1:0] MODE_OFF     = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                key_state_q, key_state_d;
    logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
    logic                key_press_q, key_press_d;
    logic [1:0]          mode_q, mode_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [3:0]          pattern_q, pattern_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                dir_q, dir_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [BR_W-1:0]     br_cnt_q, br_cnt_d;
    logic [3:0]          led_q, led_d;

    assign step_tick = (tick_cnt_q == TICK_W'(TICK_DIV - 1));

    // A new key level is accepted only after it has differed from the accepted level for DEB_CYCLES cycles.
    always_comb begin
        sync1_d     = key_n;
        sync2_d     = sync1_q;
        key_state_d = key_state_q;
        deb_cnt_d   = '0;
        if (sync2_q != key_state_q) begin
            if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
                key_state_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
        key_press_d = key_state_q & ~key_state_d;
    end

    always_comb begin
        mode_d     = mode_q;
        tick_cnt_d = step_tick ? '0 : tick_cnt_q + 1'b1;
        pattern_d  = pattern_q;
        duty_d     = duty_q;
        dir_d      = dir_q;
        pwm_cnt_d  = pwm_cnt_q + 1'b1;
        br_cnt_d   = br_cnt_q;
        if (key_press_q) begin
            // Mode change restarts every timebase, so a coincident step is dropped.
            mode_d     = mode_q + 2'd1;
            tick_cnt_d = '0;
            br_cnt_d   = '0;
            pwm_cnt_d  = '0;
            duty_d     = '0;
            dir_d      = DIR_UP;
            pattern_d  = (mode_d == MODE_RUN) ? 4'b0001 : 4'b0000;
        end else begin
            case (mode_q)
                MODE_BLINK: begin
                    if (step_tick) pattern_d = ~pattern_q;
                end
                MODE_RUN: begin
                    if (step_tick) pattern_d = {pattern_q[2:0], pattern_q[3]};
                end
                MODE_BREATHE: begin
                    if (br_cnt_q == BR_W'(BREATHE_DIV - 1)) begin
                        br_cnt_d = '0;
                        if (dir_q == DIR_UP) begin
                            if (duty_q == DUTY_MAX) begin
                                dir_d  = DIR_DOWN;
                                duty_d = duty_q - 1'b1;
                            end else begin
                                duty_d = duty_q + 1'b1;
                            end
                        end else begin
                            if (duty_q == '0) begin
                                dir_d  = DIR_UP;
                                duty_d = PWM_BITS'(1);
                            end else begin
                                duty_d = duty_q - 1'b1;
                            end
                        end
                    end else begin
                        br_cnt_d = br_cnt_q + 1'b1;
                    end
                end
                default: pattern_d = 4'b0000;
            endcase
        end
    end

    always_comb begin
        case (mode_q)
            MODE_BLINK, MODE_RUN: led_d = pattern_q;
            MODE_BREATHE:         led_d = {4{pwm_cnt_q < duty_q}};
            default:              led_d = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            key_state_q <= 1'b1;
            deb_cnt_q   <= '0;
            key_press_q <= 1'b0;
            mode_q      <= MODE_BLINK;
            tick_cnt_q  <= '0;
            pattern_q   <= 4'b0000;
            duty_q      <= '0;
            dir_q       <= DIR_UP;
            pwm_cnt_q   <= '0;
            br_cnt_q    <= '0;
            led_q       <= 4'b0000;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            key_state_q <= key_state_d;
            deb_cnt_q   <= deb_cnt_d;
            key_press_q <= key_press_d;
            mode_q      <= mode_d;
            tick_cnt_q  <= tick_cnt_d;
            pattern_q   <= pattern_d;
            duty_q      <= duty_d;
            dir_q       <= dir_d;
            pwm_cnt_q   <= pwm_cnt_d;
            br_cnt_q    <= br_cnt_d;
            led_q       <= led_d;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed and random key activity compared each cycle
// against a behavioural model of the display modes.
module tb_led_pattern_sequencer;
    localparam int TICK_DIV    = 4;
    localparam int DEB_CYCLES  = 3;
    localparam int PWM_BITS    = 3;
    localparam int BREATHE_DIV = 2;
    localparam int PWM_PERIOD  = 1 << PWM_BITS;
    localparam int DUTY_MAX    = PWM_PERIOD - 1;

    logic       clk;
    logic       rst_n;
    logic       key_n;
    logic [3:0] led;
    logic [1:0] mode;
    logic       step_tick;

    int checkCount = 0;
    int errorCount = 0;

    // Model state: key pipeline, run length of a differing level, and display state.
    bit       mSync1, mSync2, mAccepted, mPress;
    int       mDiffRun, mMode, mPhase, mPwm, mBrPhase, mBreatheSteps;
    logic [3:0] mPattern, mLed;

    led_pattern_sequencer #(
        .TICK_DIV    (TICK_DIV),
        .DEB_CYCLES  (DEB_CYCLES),
        .PWM_BITS    (PWM_BITS),
        .BREATHE_DIV (BREATHE_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_n     (key_n),
        .led       (led),
        .mode      (mode),
        .step_tick (step_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Breathing duty as a triangle wave of the number of duty steps since entering the mode.
    function automatic int triangle(input int n);
        int p;
        p = n % (2 * DUTY_MAX);
        return (p <= DUTY_MAX) ? p : 2 * DUTY_MAX - p;
    endfunction

    task automatic modelReset();
        mSync1 = 1'b1; mSync2 = 1'b1; mAccepted = 1'b1; mPress = 1'b0;
        mDiffRun = 0; mMode = 0; mPhase = 0; mPwm = 0; mBrPhase = 0; mBreatheSteps = 0;
        mPattern = 4'b0000; mLed = 4'b0000;
    endtask

    task automatic modelStep();
        int  duty;
        bit  tick;
        bit  newPress;
        if (!rst_n) begin
            modelReset();
            return;
        end
        duty = triangle(mBreatheSteps);
        tick = (mPhase == TICK_DIV - 1);
        case (mMode)
            0, 1:    mLed = mPattern;
            2:       mLed = (mPwm < duty) ? 4'hF : 4'h0;
            default: mLed = 4'h0;
        endcase
        if (mPress) begin
            mMode = (mMode + 1) % 4;
            mPhase = 0; mPwm = 0; mBrPhase = 0; mBreatheSteps = 0;
            mPattern = (mMode == 1) ? 4'b0001 : 4'b0000;
        end else begin
            mPhase = (mPhase + 1) % TICK_DIV;
            mPwm = (mPwm + 1) % PWM_PERIOD;
            if (mMode == 2) begin
                mBrPhase++;
                if (mBrPhase == BREATHE_DIV) begin
                    mBrPhase = 0;
                    mBreatheSteps++;
                end
            end
            if (mMode == 3) mPattern = 4'b0000;
            else if (tick && mMode == 0) mPattern = ~mPattern;
            else if (tick && mMode == 1) mPattern = (mPattern << 1) | (mPattern >> 3);
        end
        newPress = 1'b0;
        if (mSync2 != mAccepted) begin
            mDiffRun++;
            if (mDiffRun == DEB_CYCLES) begin
                newPress = mAccepted;
                mAccepted = mSync2;
                mDiffRun = 0;
            end
        end else begin
            mDiffRun = 0;
        end
        mPress = newPress;
        mSync2 = mSync1;
        mSync1 = key_n;
    endtask

    task automatic runCycle();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput("led", 32'(led), 32'(mLed));
        checkOutput("mode", 32'(mode), 32'(mMode));
        checkOutput("step_tick", 32'(step_tick), 32'(mPhase == TICK_DIV - 1));
    endtask

    task automatic applyStimulus(input logic level, input int cycles);
        key_n = level;
        repeat (cycles) runCycle();
    endtask

    task automatic pressKey();
        applyStimulus(1'b0, 6);
        applyStimulus(1'b1, 8);
    endtask

    // Directed phases follow the intended usage, then random key activity.
    initial begin
        rst_n = 1'b0;
        key_n = 1'b1;
        modelReset();
        repeat (3) runCycle();
        rst_n = 1'b1;

        applyStimulus(1'b1, 20);

        applyStimulus(1'b0, 10);
        applyStimulus(1'b1, 25);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 2);
            applyStimulus(1'b1, 1);
        end
        applyStimulus(1'b1, 8);

        // Align the key so its press lands on a step_tick in RUN mode.
        for (int i = 0; i < TICK_DIV && mPhase != 2; i++) runCycle();
        pressKey();

        applyStimulus(1'b1, 200);
        pressKey();
        applyStimulus(1'b1, 20);
        pressKey();
        applyStimulus(1'b1, 12);
        pressKey();
        applyStimulus(1'b1, 10);

        @(posedge clk);
        modelStep();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_led", 32'(led), 32'h0);
        checkOutput("async_rst_mode", 32'(mode), 32'h0);
        modelReset();
        repeat (2) runCycle();
        rst_n = 1'b1;
        applyStimulus(1'b1, 12);

        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom_range(1, 7));
        end
        applyStimulus(1'b1, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errorCount);
        $finish;
    end

endmodule
